// File: rtl/pid_core.sv
// pid_core: sequential fixed-point PID update engine.
//
// For each start strobe it runs IDLE -> ERR -> MULP -> MULI -> MULD -> SUM.
// The P, I and D products share one multiplier. The result is added to a bias,
// saturated, and registered onto u_out.
//
// Ports
//   PCLK      : clock
//   PRESETn   : asynchronous active-low reset
//   start     : one-cycle update request (setpoint/feedback valid the cycle after)
//   setpoint  : 12-bit unsigned setpoint
//   feedback  : 12-bit unsigned measured value
//   kp/ki/kd  : 8-bit unsigned Q4.4 gains, held stable while busy
//   clr       : synchronous clear of loop history, aborts an update in flight
//   u_out     : saturated 12-bit controller output
//   done      : one-cycle pulse when u_out updates
//   busy      : update in flight
//   overrun   : sticky, set when a start arrives while busy
module pid_core #(
    parameter int INT_MAX = 32767,
    parameter int OFFSET  = 2048
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        start,
    input  logic [11:0] setpoint,
    input  logic [11:0] feedback,
    input  logic [7:0]  kp,
    input  logic [7:0]  ki,
    input  logic [7:0]  kd,
    input  logic        clr,
    output logic [11:0] u_out,
    output logic        done,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_MULP = 3'd2;
    localparam logic [2:0] S_MULI = 3'd3;
    localparam logic [2:0] S_MULD = 3'd4;
    localparam logic [2:0] S_SUM  = 3'd5;

    localparam logic signed [20:0] INT_HI = 21'(INT_MAX);
    localparam logic signed [20:0] INT_LO = -21'(INT_MAX);

    logic [2:0]          state_q, state_d;
    logic signed [12:0]  e_q, e_d;
    logic signed [12:0]  eprev_q, eprev_d;
    logic signed [19:0]  integ_q, integ_d;
    logic signed [13:0]  dd_q, dd_d;
    logic signed [31:0]  acc_q, acc_d;
    logic [11:0]         u_q, u_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;

    logic signed [12:0]  e_s;
    logic signed [20:0]  integ_sum_s;
    logic signed [19:0]  integ_clamp_s;
    logic signed [13:0]  d_s;
    logic signed [28:0]  op_a_s;
    logic signed [28:0]  op_g_s;
    logic signed [28:0]  prod_s;
    logic signed [31:0]  acc_sum_s;
    logic signed [28:0]  biased_s;
    logic [11:0]         sat_s;

    // Error, clamped integrator and derivative term computed from live inputs in ERR
    always_comb begin
        e_s         = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
        integ_sum_s = {integ_q[19], integ_q} + {{8{e_s[12]}}, e_s};
        if (integ_sum_s > INT_HI) begin
            integ_clamp_s = INT_HI[19:0];
        end else if (integ_sum_s < INT_LO) begin
            integ_clamp_s = INT_LO[19:0];
        end else begin
            integ_clamp_s = integ_sum_s[19:0];
        end
        d_s = {e_s[12], e_s} - {eprev_q[12], eprev_q};
    end

    // Shared multiplier: operand selection follows the current MUL state
    always_comb begin
        case (state_q)
            S_MULP: begin
                op_a_s = {{16{e_q[12]}}, e_q};
                op_g_s = {21'd0, kp};
            end
            S_MULI: begin
                op_a_s = {{9{integ_q[19]}}, integ_q};
                op_g_s = {21'd0, ki};
            end
            S_MULD: begin
                op_a_s = {{15{dd_q[13]}}, dd_q};
                op_g_s = {21'd0, kd};
            end
            default: begin
                op_a_s = 29'sd0;
                op_g_s = 29'sd0;
            end
        endcase
        // The true product fits in 29 bits, so truncation is exact
        prod_s    = op_a_s * op_g_s;
        acc_sum_s = acc_q + {{3{prod_s[28]}}, prod_s};
    end

    // Output scaling: acc[31:4] is the floor of acc/16, then bias and saturate
    always_comb begin
        biased_s = {acc_q[31], acc_q[31:4]} + 29'(OFFSET);
        if (biased_s < 29'sd0) begin
            sat_s = 12'd0;
        end else if (biased_s > 29'sd4095) begin
            sat_s = 12'd4095;
        end else begin
            sat_s = biased_s[11:0];
        end
    end

    // Next-state logic; clr overrides everything, including a coincident start
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        eprev_d = eprev_q;
        integ_d = integ_q;
        dd_d    = dd_q;
        acc_d   = acc_q;
        u_d     = u_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        if (clr) begin
            state_d = S_IDLE;
            integ_d = 20'sd0;
            eprev_d = 13'sd0;
            ovr_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            if (start && (state_q != S_IDLE)) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = ovr_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ERR;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ERR: begin
                    e_d     = e_s;
                    integ_d = integ_clamp_s;
                    dd_d    = d_s;
                    eprev_d = e_s;
                    acc_d   = 32'sd0;
                    state_d = S_MULP;
                end
                S_MULP: begin
                    acc_d   = acc_sum_s;
                    state_d = S_MULI;
                end
                S_MULI: begin
                    acc_d   = acc_sum_s;
                    state_d = S_MULD;
                end
                S_MULD: begin
                    acc_d   = acc_sum_s;
                    state_d = S_SUM;
                end
                S_SUM: begin
                    u_d     = sat_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            e_q     <= 13'sd0;
            eprev_q <= 13'sd0;
            integ_q <= 20'sd0;
            dd_q    <= 14'sd0;
            acc_q   <= 32'sd0;
            u_q     <= 12'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            eprev_q <= eprev_d;
            integ_q <= integ_d;
            dd_q    <= dd_d;
            acc_q   <= acc_d;
            u_q     <= u_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign u_out   = u_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: doc/pid_core.md
# pid_core

Sequential fixed-point PID compute stage that sits directly downstream of the APB register bridge. It takes the 12-bit setpoint and its one-cycle write strobe from the bridge, together with a 12-bit feedback sample. For each strobe it computes one PID update using a single shared multiplier over a five-state sequence. The saturated 12-bit result is returned to the bridge's readable PID data input.

## Interface
Parameters:
- INT_MAX, 32767: integrator clamp magnitude. The integrator is held in [-INT_MAX, +INT_MAX]. Legal range is 1..2^19-1.
- OFFSET, 2048: unsigned bias added to the scaled PID sum before saturation (mid-scale).

Ports:
- PCLK  in  1: clock.
- PRESETn  in  1: reset, asynchronous, active-low.
- start  in  1: one-cycle update request, driven by the bridge PID write strobe.
- setpoint  in  12: unsigned setpoint. It is valid from the cycle after `start`.
- feedback  in  12: unsigned measured value. It is sampled with `setpoint`.
- kp, ki, kd  in  8 each: unsigned Q4.4 gains (16 = 1.0). Quasi-static; they must not change while `busy`=1.
- clr  in  1: synchronous clear of loop history.
- u_out  out  12: saturated controller output. Reset value 0.
- done  out  1: one-cycle pulse when `u_out` updates. Reset value 0.
- busy  out  1: high while an update is in flight. Reset value 0.
- overrun  out  1: sticky flag, set when `start` is dropped. Reset value 0.

## Operation
FSM states: IDLE -> ERR -> MULP -> MULI -> MULD -> SUM -> IDLE.
- **IDLE:** `start`=1 moves to ERR.
- **ERR:** sample `setpoint` and `feedback`, then compute and register:
  - e = setpoint - feedback, as 13-bit signed.
  - integ = clamp(integ + e, ±INT_MAX), as 20-bit signed.
  - d = e - e_prev, as 14-bit signed. Then e_prev <= e.
  - acc <= 0.
- **MULP:** acc += kp*e.
- **MULI:** acc += ki*integ.
- **MULD:** acc += kd*d.
- **SUM:**
  - u_out <= sat(acc >>> 4 + OFFSET, 0..4095). The `>>>` is arithmetic and floors toward negative infinity.
  - done=1 for one cycle.
  - Return to IDLE.

Arithmetic rules:
- acc is 32-bit signed.
- Gains are zero-extended before multiplying.
- Only one multiplier is instantiated; it is shared across MULP/MULI/MULD.

`clr` behaviour:
- Zeroes integ, e_prev and overrun.
- In any non-IDLE state it aborts to IDLE: no `done`, and `u_out` holds.
- `clr` and `start` in the same IDLE cycle: `clr` wins and `start` is dropped. `overrun` is not set.

`start` while not IDLE (ERR through SUM): the request is ignored and `overrun` is set to 1. `overrun` stays set until `clr` or reset.

Reset mid-operation: all state returns to reset values immediately, and the FSM goes to IDLE.

## Timing
- `start` sampled high at edge E0 → state ERR. Setpoint and feedback are sampled at E1, i.e. the cycle after the strobe, which matches the bridge register update.
- E2 MULP, E3 MULI, E4 MULD accumulate. At E5, `u_out` updates and `done` rises for exactly one cycle.
- Latency is 5 cycles from the `start` sample to `u_out` valid.
- `busy` is high from after E0 until E5.
- A `start` at edge E5 (state SUM) counts as overrun. The earliest accepted restart is E6.
- Maximum throughput: one update per 6 cycles.
- `u_out` is stable between `done` pulses.

## Test plan
- **Reset:** PRESETn low mid-run (during MULI) → u_out=0, done=0, busy=0, overrun=0 immediately. After release, the FSM is in IDLE.
- **Proportional:** kp=16, ki=kd=0, setpoint=100, feedback=0 → done at E5, u_out=2148. Then setpoint=0, feedback=100 → u_out=1948.
- **Integral:** kp=0, ki=16, kd=0, setpoint=100, feedback=0, three runs → u_out=2148, 2248, 2348. Assert `clr`, then run once → u_out=2148.
- **Derivative:** kd=16, kp=ki=0, e goes 0 then 100 then 100 → u_out=2048, 2148, 2048.
- **Saturation and clamp:**
  - kp=255, setpoint=4095, feedback=0 → u_out=4095.
  - kp=255, setpoint=0, feedback=4095 → u_out=0.
  - ki=16, e=4095: eight runs give integ=32760; the ninth gives integ=32767, the clamp value.
- **Overrun and collisions:**
  - `start` at E2 → ignored, overrun=1, a single `done` at E5.
  - `clr` at E3 → no `done`, u_out unchanged, overrun=0.
  - `clr` and `start` together in IDLE → no run, overrun=0.
